// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module : btn_pkg
// Brief  : State encoding and timing defaults for the button repeat conditioner.
// Rev    : 1.0
// ============================================================================
package btn_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_HOLD   = ST_HOLD,
        S_REPEAT = ST_REPEAT
    } state_t;

    // Production timing at 10 MHz
    localparam int DEF_DEBOUNCE_CYCLES = 100_000;
    localparam int DEF_HOLD_DELAY      = 5_000_000;
    localparam int DEF_REPEAT_PERIOD   = 2_000_000;
    localparam int DEF_CNT_BIT         = 24;

    // Reduced timing for simulation
    localparam int TB_DEBOUNCE_CYCLES  = 4;
    localparam int TB_HOLD_DELAY       = 20;
    localparam int TB_REPEAT_PERIOD    = 8;

endpackage
`default_nettype wire

// File: rtl/button_repeat_if.sv
`default_nettype none
// ============================================================================
// Module : button_repeat_if
// Brief  : Raw button level in, conditioned pulse/level outputs back.
// Rev    : 1.0
// ============================================================================
interface button_repeat_if;

    logic button_in;
    logic one_shot_pulse;
    logic pressed;
    logic repeating;

    modport master (
        output button_in,
        input  one_shot_pulse,
        input  pressed,
        input  repeating
    );

    modport slave (
        input  button_in,
        output one_shot_pulse,
        output pressed,
        output repeating
    );

endinterface
`default_nettype wire

// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
// Module : debounce_filter
// Brief  : Two-flop synchronizer plus stable-cycle counter producing pressed.
// Rev    : 1.0
// ============================================================================
module debounce_filter
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_BIT         = DEF_CNT_BIT
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic button_in,
    output logic      pressed,
    output logic      rise,
    output logic      fall
);

    localparam logic [CNT_BIT-1:0] C_DEB_LAST = CNT_BIT'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_pressed;
    logic [CNT_BIT-1:0] r_cnt;
    logic               w_differ;
    logic               w_flip;

    assign w_differ = (r_sync2 != r_pressed);
    assign w_flip   = w_differ && (r_cnt == C_DEB_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_pressed <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= button_in;
            r_sync2 <= r_sync1;
            // Any cycle agreeing with the current level discards the partial count
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_flip) begin
                r_pressed <= r_sync2;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_BIT'(1);
            end
        end
    end

    // Strobes announce the level change that lands on the coming edge
    assign rise    = w_flip &  r_sync2;
    assign fall    = w_flip & ~r_sync2;
    assign pressed = r_pressed;

endmodule
`default_nettype wire

// File: rtl/button_repeat.sv
`default_nettype none
// ============================================================================
// Module : button_repeat
// Brief  : Debounced press pulse with hold-delay auto-repeat for panel buttons.
// Rev    : 1.0
// ============================================================================
module button_repeat
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_DELAY      = DEF_HOLD_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int ENABLE_REPEAT   = 1,
    parameter int CNT_BIT         = DEF_CNT_BIT
) (
    input  wire logic         clk,
    input  wire logic         reset,
    button_repeat_if.slave    btn
);

    localparam logic [CNT_BIT-1:0] C_HOLD_LAST   = CNT_BIT'(HOLD_DELAY - 1);
    localparam logic [CNT_BIT-1:0] C_REPEAT_LAST = CNT_BIT'(REPEAT_PERIOD - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_BIT-1:0] r_timer;
    logic [CNT_BIT-1:0] w_timer_nxt;
    logic               r_pulse;
    logic               w_pulse_nxt;
    logic               r_repeating;
    logic               w_repeating_nxt;
    logic               w_pressed;
    logic               w_rise;
    logic               w_fall;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_BIT         (CNT_BIT)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .button_in (btn.button_in),
        .pressed   (w_pressed),
        .rise      (w_rise),
        .fall      (w_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_pulse     <= 1'b0;
            r_repeating <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_pulse     <= w_pulse_nxt;
            r_repeating <= w_repeating_nxt;
        end
    end

    // A debounced fall takes priority over a coincident timer expiry
    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_pulse_nxt     = 1'b0;
        w_repeating_nxt = r_repeating;
        case (r_state)
            S_IDLE: begin
                w_timer_nxt     = '0;
                w_repeating_nxt = 1'b0;
                if (w_rise) begin
                    w_state_nxt = S_HOLD;
                    w_pulse_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_fall) begin
                    w_state_nxt     = S_IDLE;
                    w_timer_nxt     = '0;
                    w_repeating_nxt = 1'b0;
                end else if (r_timer == C_HOLD_LAST) begin
                    if (ENABLE_REPEAT != 0) begin
                        w_state_nxt     = S_REPEAT;
                        w_pulse_nxt     = 1'b1;
                        w_timer_nxt     = '0;
                        w_repeating_nxt = 1'b1;
                    end
                end else begin
                    w_timer_nxt = r_timer + CNT_BIT'(1);
                end
            end
            S_REPEAT: begin
                if (w_fall) begin
                    w_state_nxt     = S_IDLE;
                    w_timer_nxt     = '0;
                    w_repeating_nxt = 1'b0;
                end else if (r_timer == C_REPEAT_LAST) begin
                    w_pulse_nxt = 1'b1;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + CNT_BIT'(1);
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_timer_nxt     = '0;
                w_repeating_nxt = 1'b0;
            end
        endcase
    end

    assign btn.one_shot_pulse = r_pulse;
    assign btn.pressed        = w_pressed;
    assign btn.repeating      = r_repeating;

endmodule
`default_nettype wire

// File: tb/tb_button_repeat.sv
`default_nettype none
// ============================================================================
// Module : tb_button_repeat
// Brief  : Directed self-checking bench for button_repeat (repeat on and off).
// Rev    : 1.0
// ============================================================================
module tb_button_repeat;
    import btn_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    button_repeat_if rep_if ();
    button_repeat_if norep_if ();

    button_repeat #(
        .DEBOUNCE_CYCLES (TB_DEBOUNCE_CYCLES),
        .HOLD_DELAY      (TB_HOLD_DELAY),
        .REPEAT_PERIOD   (TB_REPEAT_PERIOD),
        .ENABLE_REPEAT   (1),
        .CNT_BIT         (DEF_CNT_BIT)
    ) u_dut_rep (
        .clk   (clk),
        .reset (reset),
        .btn   (rep_if)
    );

    button_repeat #(
        .DEBOUNCE_CYCLES (TB_DEBOUNCE_CYCLES),
        .HOLD_DELAY      (TB_HOLD_DELAY),
        .REPEAT_PERIOD   (TB_REPEAT_PERIOD),
        .ENABLE_REPEAT   (0),
        .CNT_BIT         (DEF_CNT_BIT)
    ) u_dut_norep (
        .clk   (clk),
        .reset (reset),
        .btn   (norep_if)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rep_if.button_in   = 1'b0;
        norep_if.button_in = 1'b0;
        step();
        step();
        n_cmp++; if (rep_if.pressed !== 1'b0) begin n_fail++; $display("FAIL reset_pressed got=%b exp=0", rep_if.pressed); end
        n_cmp++; if (rep_if.one_shot_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got=%b exp=0", rep_if.one_shot_pulse); end
        n_cmp++; if (rep_if.repeating !== 1'b0) begin n_fail++; $display("FAIL reset_repeating got=%b exp=0", rep_if.repeating); end
        n_cmp++; if (norep_if.pressed !== 1'b0) begin n_fail++; $display("FAIL reset_norep_pressed got=%b exp=0", norep_if.pressed); end
        n_cmp++; if (norep_if.one_shot_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_norep_pulse got=%b exp=0", norep_if.one_shot_pulse); end
        n_cmp++; if (norep_if.repeating !== 1'b0) begin n_fail++; $display("FAIL reset_norep_repeating got=%b exp=0", norep_if.repeating); end
        reset = 1'b0;
        step();
    endtask

    // High sampled on edges 1..10: pressed/pulse after edge 6, release lands after edge 16
    task automatic test_clean_tap();
        logic exp_pr, exp_pu;
        rep_if.button_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 10) rep_if.button_in = 1'b0;
            exp_pr = (i >= 6) && (i < 16);
            exp_pu = (i == 6);
            n_cmp++; if (rep_if.pressed !== exp_pr) begin n_fail++; $display("FAIL tap_pressed cyc=%0d got=%b exp=%b", i, rep_if.pressed, exp_pr); end
            n_cmp++; if (rep_if.one_shot_pulse !== exp_pu) begin n_fail++; $display("FAIL tap_pulse cyc=%0d got=%b exp=%b", i, rep_if.one_shot_pulse, exp_pu); end
            n_cmp++; if (rep_if.repeating !== 1'b0) begin n_fail++; $display("FAIL tap_repeating cyc=%0d got=%b exp=0", i, rep_if.repeating); end
        end
    endtask

    task automatic test_bounce();
        for (int i = 1; i <= 30; i++) begin
            rep_if.button_in = (i <= 20) ? (((i - 1) / 2) % 2 == 0) : 1'b0;
            step();
            n_cmp++; if (rep_if.pressed !== 1'b0) begin n_fail++; $display("FAIL bounce_pressed cyc=%0d got=%b exp=0", i, rep_if.pressed); end
            n_cmp++; if (rep_if.one_shot_pulse !== 1'b0) begin n_fail++; $display("FAIL bounce_pulse cyc=%0d got=%b exp=0", i, rep_if.one_shot_pulse); end
        end
    endtask

    // Press pulse at 6, repeats at 26,34,42,50,58; pressed low after edge 64
    task automatic test_hold_repeat();
        logic exp_pr, exp_pu, exp_rp;
        int   pulses = 0;
        rep_if.button_in = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            step();
            if (i == 58) rep_if.button_in = 1'b0;
            exp_pr = (i >= 6) && (i < 64);
            exp_rp = exp_pr && (i >= 26);
            exp_pu = exp_pr && ((i == 6) || ((i >= 26) && ((i - 26) % 8 == 0)));
            if (rep_if.one_shot_pulse === 1'b1) pulses++;
            n_cmp++; if (rep_if.pressed !== exp_pr) begin n_fail++; $display("FAIL hold_pressed cyc=%0d got=%b exp=%b", i, rep_if.pressed, exp_pr); end
            n_cmp++; if (rep_if.one_shot_pulse !== exp_pu) begin n_fail++; $display("FAIL hold_pulse cyc=%0d got=%b exp=%b", i, rep_if.one_shot_pulse, exp_pu); end
            n_cmp++; if (rep_if.repeating !== exp_rp) begin n_fail++; $display("FAIL hold_repeating cyc=%0d got=%b exp=%b", i, rep_if.repeating, exp_rp); end
        end
        n_cmp++; if (pulses != 6) begin n_fail++; $display("FAIL hold_pulse_count got=%0d exp=6", pulses); end
    endtask

    // Release lands after edge 66, exactly when the timer reaches REPEAT_PERIOD-1
    task automatic test_release_on_repeat();
        logic exp_pr, exp_pu, exp_rp;
        int   pulses = 0;
        rep_if.button_in = 1'b1;
        for (int i = 1; i <= 72; i++) begin
            step();
            if (i == 60) rep_if.button_in = 1'b0;
            exp_pr = (i >= 6) && (i < 66);
            exp_rp = exp_pr && (i >= 26);
            exp_pu = exp_pr && ((i == 6) || ((i >= 26) && ((i - 26) % 8 == 0)));
            if (rep_if.one_shot_pulse === 1'b1) pulses++;
            n_cmp++; if (rep_if.one_shot_pulse !== exp_pu) begin n_fail++; $display("FAIL coinc_pulse cyc=%0d got=%b exp=%b", i, rep_if.one_shot_pulse, exp_pu); end
            n_cmp++; if (rep_if.repeating !== exp_rp) begin n_fail++; $display("FAIL coinc_repeating cyc=%0d got=%b exp=%b", i, rep_if.repeating, exp_rp); end
            n_cmp++; if (rep_if.pressed !== exp_pr) begin n_fail++; $display("FAIL coinc_pressed cyc=%0d got=%b exp=%b", i, rep_if.pressed, exp_pr); end
        end
        n_cmp++; if (pulses != 6) begin n_fail++; $display("FAIL coinc_pulse_count got=%0d exp=6", pulses); end
        // A fresh tap must behave as from IDLE with a cleared timer
        rep_if.button_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 10) rep_if.button_in = 1'b0;
            n_cmp++; if (rep_if.one_shot_pulse !== (i == 6)) begin n_fail++; $display("FAIL coinc_retap_pulse cyc=%0d got=%b exp=%b", i, rep_if.one_shot_pulse, (i == 6)); end
            n_cmp++; if (rep_if.repeating !== 1'b0) begin n_fail++; $display("FAIL coinc_retap_repeating cyc=%0d got=%b exp=0", i, rep_if.repeating); end
        end
    endtask

    task automatic test_reset_in_repeat();
        rep_if.button_in = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (i == 26) begin
                n_cmp++; if (rep_if.one_shot_pulse !== 1'b1) begin n_fail++; $display("FAIL rst_first_repeat got=%b exp=1", rep_if.one_shot_pulse); end
            end
        end
        n_cmp++; if (rep_if.repeating !== 1'b1) begin n_fail++; $display("FAIL rst_pre_repeating got=%b exp=1", rep_if.repeating); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++; if (rep_if.pressed !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pressed got=%b exp=0", rep_if.pressed); end
        n_cmp++; if (rep_if.one_shot_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pulse got=%b exp=0", rep_if.one_shot_pulse); end
        n_cmp++; if (rep_if.repeating !== 1'b0) begin n_fail++; $display("FAIL rst_mid_repeating got=%b exp=0", rep_if.repeating); end
        for (int j = 1; j <= 6; j++) begin
            step();
            n_cmp++; if (rep_if.one_shot_pulse !== (j == 6)) begin n_fail++; $display("FAIL rst_repress_pulse cyc=%0d got=%b exp=%b", j, rep_if.one_shot_pulse, (j == 6)); end
            n_cmp++; if (rep_if.pressed !== (j == 6)) begin n_fail++; $display("FAIL rst_repress_pressed cyc=%0d got=%b exp=%b", j, rep_if.pressed, (j == 6)); end
            n_cmp++; if (rep_if.repeating !== 1'b0) begin n_fail++; $display("FAIL rst_repress_repeating cyc=%0d got=%b exp=0", j, rep_if.repeating); end
        end
        rep_if.button_in = 1'b0;
        for (int j = 1; j <= 12; j++) step();
        n_cmp++; if (rep_if.pressed !== 1'b0) begin n_fail++; $display("FAIL rst_release_pressed got=%b exp=0", rep_if.pressed); end
    endtask

    task automatic test_no_repeat();
        logic exp_pr;
        int   pulses = 0;
        norep_if.button_in = 1'b1;
        for (int i = 1; i <= 110; i++) begin
            step();
            if (i == 100) norep_if.button_in = 1'b0;
            exp_pr = (i >= 6) && (i < 106);
            if (norep_if.one_shot_pulse === 1'b1) pulses++;
            n_cmp++; if (norep_if.one_shot_pulse !== (i == 6)) begin n_fail++; $display("FAIL norep_pulse cyc=%0d got=%b exp=%b", i, norep_if.one_shot_pulse, (i == 6)); end
            n_cmp++; if (norep_if.repeating !== 1'b0) begin n_fail++; $display("FAIL norep_repeating cyc=%0d got=%b exp=0", i, norep_if.repeating); end
            n_cmp++; if (norep_if.pressed !== exp_pr) begin n_fail++; $display("FAIL norep_pressed cyc=%0d got=%b exp=%b", i, norep_if.pressed, exp_pr); end
        end
        n_cmp++; if (pulses != 1) begin n_fail++; $display("FAIL norep_pulse_count got=%0d exp=1", pulses); end
    endtask

    initial begin
        test_reset();
        test_clean_tap();
        test_bounce();
        test_hold_repeat();
        test_release_on_repeat();
        test_reset_in_repeat();
        test_no_repeat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
